// File: rtl/spi_pkg.sv
// Shared constants for the SPI serial-to-parallel deserializer family.
package spi_pkg;

  // Word length used when the instantiating design does not override it
  localparam int DEFAULT_WL = 96;

  // Largest number of MOSI lanes a single deserializer supports
  localparam int MAX_LANES = 8;

  // Bit-order selectors for the lane shift registers
  localparam bit MSB_FIRST_C = 1'b1;
  localparam bit LSB_FIRST_C = 1'b0;

endpackage

// File: rtl/spi_s2p_deserializer_s2p_lane.sv
// One serial lane: a WL-bit shift register with strobe, clear and bit order.
// cand_o is the register value after the current strobe, which lets the top
// capture a finished word, including its last bit, on the same edge.
module s2p_lane
  import spi_pkg::*;
#(
  parameter int WL        = DEFAULT_WL,
  parameter bit MSB_FIRST = MSB_FIRST_C
) (
  input  logic          clk,
  input  logic          iRST_n,
  input  logic          shift_i,
  input  logic          clear_i,
  input  logic          bit_i,
  output logic [WL-1:0] cand_o
);

  logic [WL-1:0] sr_q;
  logic [WL-1:0] sr_d;
  logic [WL-1:0] shifted;

  // Shifted value and next-state selection: clear beats a shift strobe
  always_comb begin
    shifted = (MSB_FIRST == MSB_FIRST_C) ? {sr_q[WL-2:0], bit_i}
                                         : {bit_i, sr_q[WL-1:1]};
    sr_d = sr_q;
    if (clear_i)
      sr_d = '0;
    else if (shift_i)
      sr_d = shifted;
  end

  // Shift register state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!iRST_n)
      sr_q <= '0;
    else
      sr_q <= sr_d;
  end

  assign cand_o = shifted;

endmodule

// File: rtl/spi_s2p_deserializer.sv
// Multi-lane SPI serial-to-parallel deserializer. Counts bits per word,
// moves completed words into a valid/ready holding register and reports
// dropped words (overrun) and frames closed mid-word (frag).
module spi_s2p_deserializer
  import spi_pkg::*;
#(
  parameter int WL        = DEFAULT_WL,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = MSB_FIRST_C,
  localparam int CNT_W    = $clog2(WL)
) (
  input  logic                  clk,
  input  logic                  iRST_n,
  input  logic [LANES-1:0]      in,
  input  logic                  en,
  input  logic                  frame,
  output logic [WL*LANES-1:0]   out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic                  frag,
  output logic [CNT_W-1:0]      bit_cnt
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WL - 1);

  logic                shift;
  logic                clear;
  logic                wordDone;
  logic                consume;
  logic [WL*LANES-1:0] cand;

  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WL*LANES-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic                frag_q, frag_d;

  assign shift    = frame & en;
  assign clear    = ~frame;
  assign wordDone = shift && (bit_cnt_q == LAST_BIT);
  assign consume  = out_valid_q & out_ready;

  // One shift register per lane, all strobed and cleared together
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    s2p_lane #(
      .WL        (WL),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk     (clk),
      .iRST_n  (iRST_n),
      .shift_i (shift),
      .clear_i (clear),
      .bit_i   (in[k]),
      .cand_o  (cand[k*WL +: WL])
    );
  end

  // Bit counter, holding register, handshake and error flag next-state logic
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    frag_d      = 1'b0;

    if (!frame) begin
      bit_cnt_d = '0;
      frag_d    = (bit_cnt_q != '0);
    end else if (en) begin
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
    end

    if (consume)
      out_valid_d = 1'b0;

    if (ovr_clr)
      overrun_d = 1'b0;

    if (wordDone) begin
      if (!out_valid_q || out_ready) begin
        out_d       = cand;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Registered state; reset takes priority over every other input
  always_ff @(posedge clk) begin
    if (!iRST_n) begin
      bit_cnt_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frag_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frag_q      <= frag_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frag      = frag_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_spi_s2p_deserializer.sv
// Directed bench for spi_s2p_deserializer: MSB-first, LSB-first and
// two-lane instances driven from shared control signals.
module tb_spi_s2p_deserializer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       en;
  logic       frame;
  logic       rdy;
  logic       clr;
  logic       inA;
  logic [1:0] inC;

  logic [7:0]  aOut, bOut;
  logic [15:0] cOut;
  logic        aValid, bValid, cValid;
  logic        aOvr, bOvr, cOvr;
  logic        aFrag, bFrag, cFrag;
  logic [2:0]  aCnt, bCnt, cCnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  spi_s2p_deserializer #(.WL(8), .LANES(1), .MSB_FIRST(1'b1)) dutA (
    .clk(clk), .iRST_n(rstN), .in(inA), .en(en), .frame(frame),
    .out(aOut), .out_valid(aValid), .out_ready(rdy), .overrun(aOvr),
    .ovr_clr(clr), .frag(aFrag), .bit_cnt(aCnt)
  );

  spi_s2p_deserializer #(.WL(8), .LANES(1), .MSB_FIRST(1'b0)) dutB (
    .clk(clk), .iRST_n(rstN), .in(inA), .en(en), .frame(frame),
    .out(bOut), .out_valid(bValid), .out_ready(rdy), .overrun(bOvr),
    .ovr_clr(clr), .frag(bFrag), .bit_cnt(bCnt)
  );

  spi_s2p_deserializer #(.WL(8), .LANES(2), .MSB_FIRST(1'b1)) dutC (
    .clk(clk), .iRST_n(rstN), .in(inC), .en(en), .frame(frame),
    .out(cOut), .out_valid(cValid), .out_ready(rdy), .overrun(cOvr),
    .ovr_clr(clr), .frag(cFrag), .bit_cnt(cCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shiftBit(input logic a, input logic [1:0] c);
    en  = 1'b1;
    inA = a;
    inC = c;
    tick();
    en  = 1'b0;
  endtask

  task automatic sendWordA(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) shiftBit(v[i], 2'b00);
  endtask

  task automatic test_reset();
    rstN = 1'b0; en = 1'b0; frame = 1'b0; rdy = 1'b0; clr = 1'b0; inA = 1'b0; inC = 2'b00;
    tick(); tick();
    compared++; if (aOut !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_out got %h exp 00", aOut); end
    compared++; if (aValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b exp 0", aValid); end
    compared++; if (aOvr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun got %b exp 0", aOvr); end
    compared++; if (aFrag !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frag got %b exp 0", aFrag); end
    compared++; if (aCnt !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_cnt got %0d exp 0", aCnt); end
    compared++; if (cOut !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_out_c got %h exp 0000", cOut); end
    rstN = 1'b1; frame = 1'b1;
  endtask

  task automatic test_msb_first();
    logic [7:0] bits = 8'b1010_0101;
    rdy = 1'b1;
    for (int i = 7; i >= 1; i--) shiftBit(bits[i], 2'b00);
    compared++; if (aCnt !== 3'd7) begin mismatched++; $display("[TB] FAIL msb_cnt7 got %0d exp 7", aCnt); end
    compared++; if (aValid !== 1'b0) begin mismatched++; $display("[TB] FAIL msb_early_valid got %b exp 0", aValid); end
    shiftBit(bits[0], 2'b00);
    compared++; if (aOut !== 8'hA5) begin mismatched++; $display("[TB] FAIL msb_out got %h exp a5", aOut); end
    compared++; if (aValid !== 1'b1) begin mismatched++; $display("[TB] FAIL msb_valid got %b exp 1", aValid); end
    compared++; if (aCnt !== 3'd0) begin mismatched++; $display("[TB] FAIL msb_cnt_wrap got %0d exp 0", aCnt); end
    tick();
    compared++; if (aValid !== 1'b0) begin mismatched++; $display("[TB] FAIL msb_consumed got %b exp 0", aValid); end
  endtask

  task automatic test_lsb_first();
    rdy = 1'b1;
    sendWordA(8'h80);
    compared++; if (bOut !== 8'h01) begin mismatched++; $display("[TB] FAIL lsb_out got %h exp 01", bOut); end
    compared++; if (bValid !== 1'b1) begin mismatched++; $display("[TB] FAIL lsb_valid got %b exp 1", bValid); end
    compared++; if (aOut !== 8'h80) begin mismatched++; $display("[TB] FAIL lsb_msb_ref got %h exp 80", aOut); end
    tick();
  endtask

  task automatic test_multi_lane();
    logic [7:0] l0 = 8'h3C;
    logic [7:0] l1 = 8'hC3;
    rdy = 1'b1;
    for (int i = 7; i >= 0; i--) shiftBit(1'b0, {l1[i], l0[i]});
    compared++; if (cOut !== 16'hC33C) begin mismatched++; $display("[TB] FAIL lane_out got %h exp c33c", cOut); end
    compared++; if (cValid !== 1'b1) begin mismatched++; $display("[TB] FAIL lane_valid got %b exp 1", cValid); end
    tick();
    compared++; if (cValid !== 1'b0) begin mismatched++; $display("[TB] FAIL lane_single_valid got %b exp 0", cValid); end
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    sendWordA(8'h11);
    compared++; if (aOut !== 8'h11) begin mismatched++; $display("[TB] FAIL ovr_first_out got %h exp 11", aOut); end
    compared++; if (aOvr !== 1'b0) begin mismatched++; $display("[TB] FAIL ovr_first_flag got %b exp 0", aOvr); end
    sendWordA(8'h22);
    compared++; if (aOut !== 8'h11) begin mismatched++; $display("[TB] FAIL ovr_kept_out got %h exp 11", aOut); end
    compared++; if (aOvr !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_set got %b exp 1", aOvr); end
    compared++; if (aValid !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_valid got %b exp 1", aValid); end
    tick();
    compared++; if (aOvr !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_sticky got %b exp 1", aOvr); end
    clr = 1'b1; tick(); clr = 1'b0;
    compared++; if (aOvr !== 1'b0) begin mismatched++; $display("[TB] FAIL ovr_clear got %b exp 0", aOvr); end
    rdy = 1'b1; tick();
    compared++; if (aValid !== 1'b0) begin mismatched++; $display("[TB] FAIL ovr_drain got %b exp 0", aValid); end
    compared++; if (aOut !== 8'h11) begin mismatched++; $display("[TB] FAIL ovr_drain_out got %h exp 11", aOut); end
    // a drop coinciding with ovr_clr must leave overrun set
    rdy = 1'b0;
    sendWordA(8'h33);
    for (int i = 7; i >= 1; i--) shiftBit(1'b0, 2'b00);
    clr = 1'b1; shiftBit(1'b0, 2'b00); clr = 1'b0;
    compared++; if (aOvr !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_set_wins got %b exp 1", aOvr); end
    compared++; if (aOut !== 8'h33) begin mismatched++; $display("[TB] FAIL ovr_set_wins_out got %h exp 33", aOut); end
    clr = 1'b1; tick(); clr = 1'b0;
    rdy = 1'b1; tick();
  endtask

  task automatic test_simul_consume();
    logic [7:0] w = 8'h22;
    rdy = 1'b0;
    sendWordA(8'h11);
    compared++; if (aValid !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_valid got %b exp 1", aValid); end
    for (int i = 7; i >= 1; i--) shiftBit(w[i], 2'b00);
    rdy = 1'b1;
    shiftBit(w[0], 2'b00);
    compared++; if (aOut !== 8'h22) begin mismatched++; $display("[TB] FAIL sim_out got %h exp 22", aOut); end
    compared++; if (aValid !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_valid_hold got %b exp 1", aValid); end
    compared++; if (aOvr !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_overrun got %b exp 0", aOvr); end
    tick();
    compared++; if (aValid !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_drain got %b exp 0", aValid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w = 16'hA53C;
    rdy = 1'b1;
    en = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      inA = w[i];
      tick();
      if (i == 8) begin
        compared++; if (aOut !== 8'hA5) begin mismatched++; $display("[TB] FAIL b2b_first got %h exp a5", aOut); end
      end
    end
    en = 1'b0;
    compared++; if (aOut !== 8'h3C) begin mismatched++; $display("[TB] FAIL b2b_second got %h exp 3c", aOut); end
    compared++; if (aValid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_valid got %b exp 1", aValid); end
    tick();
  endtask

  task automatic test_fragment();
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) shiftBit(1'b1, 2'b11);
    compared++; if (aCnt !== 3'd3) begin mismatched++; $display("[TB] FAIL frag_cnt3 got %0d exp 3", aCnt); end
    frame = 1'b0; en = 1'b1; tick();
    compared++; if (aFrag !== 1'b1) begin mismatched++; $display("[TB] FAIL frag_pulse got %b exp 1", aFrag); end
    compared++; if (aCnt !== 3'd0) begin mismatched++; $display("[TB] FAIL frag_cnt_clr got %0d exp 0", aCnt); end
    compared++; if (aOut !== 8'h3C) begin mismatched++; $display("[TB] FAIL frag_out_kept got %h exp 3c", aOut); end
    tick();
    compared++; if (aFrag !== 1'b0) begin mismatched++; $display("[TB] FAIL frag_one_cycle got %b exp 0", aFrag); end
    compared++; if (aCnt !== 3'd0) begin mismatched++; $display("[TB] FAIL frag_en_ignored got %0d exp 0", aCnt); end
    en = 1'b0; frame = 1'b1;
    // no stale bits from the fragment: fresh word starts from a cleared register
    sendWordA(8'h5A);
    compared++; if (aOut !== 8'h5A) begin mismatched++; $display("[TB] FAIL frag_next_word got %h exp 5a", aOut); end
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) shiftBit(1'b1, 2'b11);
    rstN = 1'b0; tick();
    compared++; if (aOut !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_out got %h exp 00", aOut); end
    compared++; if (aValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid got %b exp 0", aValid); end
    compared++; if (aCnt !== 3'd0) begin mismatched++; $display("[TB] FAIL rst_cnt got %0d exp 0", aCnt); end
    compared++; if (aFrag !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_frag got %b exp 0", aFrag); end
    rstN = 1'b1; tick();
    compared++; if (aFrag !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_frag_after got %b exp 0", aFrag); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_multi_lane();
    test_overrun();
    test_simul_consume();
    test_back_to_back();
    test_fragment();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
